// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing one transmitter write port among N_REQ byte lanes.
// Optional feature: define UART_ARB_HDR_EN to emit a header byte (8'hA0 | owner) before each grant's data.
module uart_tx_arbiter #(
    parameter int N_REQ   = 4,
    parameter int MAX_PKT = 64
) (
    input  logic                 clk,
    input  logic                 srst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]     req_last,
    output logic [N_REQ-1:0]     req_ready,
    output logic [7:0]           tx_din,
    output logic                 tx_wr_en,
    input  logic                 tx_full,
    output logic [N_REQ-1:0]     grant,
    output logic                 busy,
    output logic                 ovf_err
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
`ifdef UART_ARB_HDR_EN
        HEADER,
`endif
        XFER
    } state_t;

    state_t           state, state_n;
    logic [N_REQ-1:0] grant_n;
    logic [IW-1:0]    owner, owner_n;
    logic [IW-1:0]    rr_ptr, rr_n;
    logic [7:0]       byte_cnt, cnt_n, cnt_inc;
    logic             ovf_n;
    logic             pick_found;
    logic [IW-1:0]    pick;
    logic [7:0]       lane_data;
    logic             xfer, last_hit, max_hit;

    // First valid lane at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        pick_found = 1'b0;
        pick       = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!pick_found && req_valid[(int'(rr_ptr) + i) % N_REQ]) begin
                pick_found = 1'b1;
                pick       = IW'((int'(rr_ptr) + i) % N_REQ);
            end
        end
    end

    assign lane_data = req_data[int'(owner)*8 +: 8];
    assign xfer      = (state == XFER) && req_valid[owner] && !tx_full;
    assign last_hit  = req_last[owner];
    assign cnt_inc   = byte_cnt + 8'd1;
    assign max_hit   = (cnt_inc == 8'(MAX_PKT));
    assign busy      = (state != IDLE);

    always_comb begin
        tx_wr_en  = 1'b0;
        tx_din    = 8'h00;
        req_ready = '0;
        state_n   = state;
        grant_n   = grant;
        owner_n   = owner;
        rr_n      = rr_ptr;
        cnt_n     = byte_cnt;
        ovf_n     = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    grant_n       = '0;
                    grant_n[pick] = 1'b1;
                    owner_n       = pick;
                    cnt_n         = 8'd0;
`ifdef UART_ARB_HDR_EN
                    state_n       = HEADER;
`else
                    state_n       = XFER;
`endif
                end
            end
`ifdef UART_ARB_HDR_EN
            HEADER: begin
                if (!tx_full) begin
                    tx_wr_en = 1'b1;
                    tx_din   = 8'hA0 | 8'(owner);
                    state_n  = XFER;
                end
            end
`endif
            XFER: begin
                if (xfer) begin
                    tx_wr_en         = 1'b1;
                    tx_din           = lane_data;
                    req_ready[owner] = 1'b1;
                    cnt_n            = cnt_inc;
                    // A byte that is both last and the MAX_PKT-th is a normal release.
                    if (last_hit || max_hit) begin
                        state_n = IDLE;
                        grant_n = '0;
                        rr_n    = (int'(owner) == N_REQ-1) ? '0 : owner + 1'b1;
                        ovf_n   = !last_hit;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state    <= IDLE;
            grant    <= '0;
            owner    <= '0;
            rr_ptr   <= '0;
            byte_cnt <= 8'd0;
            ovf_err  <= 1'b0;
        end else begin
            state    <= state_n;
            grant    <= grant_n;
            owner    <= owner_n;
            rr_ptr   <= rr_n;
            byte_cnt <= cnt_n;
            ovf_err  <= ovf_n;
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized + directed bench for uart_tx_arbiter; expected byte streams come from a packet-level model.
module tb_uart_tx_arbiter;
    localparam int N    = 4;
    localparam int MAXP = 64;
`ifdef UART_ARB_HDR_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    logic           clk = 1'b0;
    logic           srst;
    logic [N-1:0]   req_valid, req_last, req_ready, grant;
    logic [8*N-1:0] req_data;
    logic [7:0]     tx_din;
    logic           tx_wr_en, tx_full, busy, ovf_err;

    uart_tx_arbiter #(.N_REQ(N), .MAX_PKT(MAXP)) dut (
        .clk(clk), .srst(srst), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .tx_din(tx_din),
        .tx_wr_en(tx_wr_en), .tx_full(tx_full), .grant(grant), .busy(busy),
        .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    int         checks = 0, errors = 0, cyc = 0, ovf_cnt = 0, full_pct = 0, exp_ovf = 0;
    logic [8:0] src [N][$];
    logic [7:0] cap_q[$], exp_q[$];
    int         cap_cyc[$];
    logic       obs_wr;
    logic [N-1:0] obs_ready, obs_grant;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic drive_lanes();
        for (int k = 0; k < N; k++) begin
            if (src[k].size() > 0) begin
                req_valid[k]       = 1'b1;
                req_data[8*k +: 8] = src[k][0][7:0];
                req_last[k]        = src[k][0][8];
            end else begin
                req_valid[k]       = 1'b0;
                req_data[8*k +: 8] = 8'h00;
                req_last[k]        = 1'b0;
            end
        end
        tx_full = (int'($urandom_range(0, 99)) < full_pct);
    endtask

    // Observe at negedge, advance a clock, pop accepted bytes, re-drive.
    task automatic step();
        logic [N-1:0] xm;
        @(negedge clk);
        xm        = req_valid & req_ready;
        obs_wr    = tx_wr_en;
        obs_ready = req_ready;
        obs_grant = grant;
        if (tx_wr_en) begin
            cap_q.push_back(tx_din);
            cap_cyc.push_back(cyc);
        end
        if (ovf_err) ovf_cnt++;
        chk("ready_nonowner", 32'(req_ready & ~grant), 32'd0);
        @(posedge clk);
        cyc++;
        #1;
        for (int k = 0; k < N; k++)
            if (xm[k]) void'(src[k].pop_front());
        drive_lanes();
    endtask

    task automatic push(input int k, input logic [7:0] d, input logic last);
        src[k].push_back({last, d});
    endtask

    function automatic logic any_src();
        logic a = 1'b0;
        for (int k = 0; k < N; k++) if (src[k].size() > 0) a = 1'b1;
        return a;
    endfunction

    task automatic do_reset();
        srst = 1'b1;
        for (int k = 0; k < N; k++) src[k].delete();
        full_pct = 0;
        drive_lanes();
        step();
        step();
        srst = 1'b0;
        cap_q.delete();
        cap_cyc.delete();
        ovf_cnt = 0;
    endtask

    // Packet-level reference: all queued lanes are continuously valid, so grants follow
    // round-robin over non-empty lanes, each grant taking bytes up to last or MAXP.
    task automatic build_model();
        logic [8:0] m [N][$];
        logic [8:0] b;
        int rr, g, n;
        rr = 0;
        exp_q.delete();
        exp_ovf = 0;
        for (int k = 0; k < N; k++) m[k] = src[k];
        while (1) begin
            g = -1;
            for (int i = 0; i < N; i++)
                if (g < 0 && m[(rr + i) % N].size() > 0) g = (rr + i) % N;
            if (g < 0) break;
            if (HDR == 1) exp_q.push_back(8'hA0 | 8'(g));
            n = 0;
            while (m[g].size() > 0) begin
                b = m[g].pop_front();
                exp_q.push_back(b[7:0]);
                n++;
                if (b[8]) break;
                if (n == MAXP) begin
                    exp_ovf++;
                    break;
                end
            end
            rr = (g + 1) % N;
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((any_src() || busy) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) chk("drain_timeout", 32'd1, 32'd0);
        step();
    endtask

    task automatic wait_bytes(input int want, input int budget);
        int n = 0;
        while (cap_q.size() < want && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) chk("wait_timeout", 32'd1, 32'd0);
    endtask

    task automatic check_stream(input string tag);
        chk({tag, "_len"}, 32'(cap_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++)
            chk(tag, 32'(cap_q[i]), 32'(exp_q[i]));
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr_cnt, viol, np, len, sel;
        srst = 1'b1; tx_full = 1'b0;
        req_valid = '0; req_last = '0; req_data = '0;
        do_reset();

        // Reset values and a long idle stretch
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovf", 32'(ovf_err), 32'd0);
        chk("rst_wr_en", 32'(tx_wr_en), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_din", 32'(tx_din), 32'd0);
        wr_cnt = 0;
        repeat (100) begin
            step();
            if (obs_wr) wr_cnt++;
        end
        chk("idle_wr_cnt", 32'(wr_cnt), 32'd0);
        chk("idle_grant", 32'(grant), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        // Lanes 1 and 3 with 3-byte packets
        push(1, 8'h11, 0); push(1, 8'h22, 0); push(1, 8'h33, 1);
        push(3, 8'h44, 0); push(3, 8'h55, 0); push(3, 8'h66, 1);
        drive_lanes();
        build_model();
        step();
        chk("rr_first_grant", 32'(grant), 32'b0010);
        chk("rr_first_busy", 32'(busy), 32'd1);
        drain(200);
        check_stream("pkt_1010");
        chk("pkt_first_byte", 32'(cap_q[HDR]), 32'h11);
        chk("pkt_second_pkt", 32'(cap_q[3 + 2*HDR]), 32'h44);
        chk("pkt_bubble", 32'(cap_cyc[3 + HDR] - cap_cyc[2 + HDR]), 32'd2);

        // 70 bytes on lane 2 without last: forced release after 64
        do_reset();
        for (int i = 0; i < 70; i++) push(2, 8'(i + 1), 0);
        drive_lanes();
        build_model();
        repeat (90) step();
        check_stream("ovf_stream");
        chk("ovf_pulses", 32'(ovf_cnt), 32'd1);
        chk("ovf_release_gap", 32'(cap_cyc[64 + HDR] - cap_cyc[63 + HDR]), 32'd2);
        chk("ovf_tail_grant", 32'(grant), 32'b0100);
        chk("ovf_tail_busy", 32'(busy), 32'd1);

        // tx_full held for 20 cycles mid-packet
        do_reset();
        for (int i = 0; i < 5; i++) push(0, 8'hC1 + 8'(i), i == 4);
        drive_lanes();
        build_model();
        wait_bytes(2 + HDR, 50);
        full_pct = 100;
        drive_lanes();
        viol = 0;
        repeat (20) begin
            step();
            if (obs_wr || obs_ready != '0 || obs_grant != 4'b0001) viol++;
        end
        chk("full_viol", 32'(viol), 32'd0);
        chk("full_bytes", 32'(cap_q.size()), 32'(2 + HDR));
        full_pct = 0;
        drive_lanes();
        drain(100);
        check_stream("full_stream");

        // srst during byte 2 of 5 after rr_ptr was moved to 3
        do_reset();
        push(2, 8'h77, 1);
        drive_lanes();
        drain(50);
        cap_q.delete(); cap_cyc.delete();
        for (int i = 0; i < 5; i++) push(2, 8'hB1 + 8'(i), i == 4);
        drive_lanes();
        wait_bytes(1 + HDR, 50);
        srst = 1'b1;
        step();
        srst = 1'b0;
        for (int k = 0; k < N; k++) src[k].delete();
        drive_lanes();
        chk("srst_grant", 32'(grant), 32'd0);
        chk("srst_busy", 32'(busy), 32'd0);
        chk("srst_bytes", 32'(cap_q.size()), 32'(2 + HDR));
        push(0, 8'h01, 1);
        push(3, 8'h03, 1);
        drive_lanes();
        step();
        chk("srst_rr_restart", 32'(grant), 32'b0001);
        drain(50);

        // Single-byte packet on lane 3, header presence depends on build
        do_reset();
        push(3, 8'h5A, 1);
        drive_lanes();
        drain(50);
        exp_q.delete();
        if (HDR == 1) exp_q.push_back(8'hA3);
        exp_q.push_back(8'h5A);
        check_stream("hdr");

        // Randomized packet mixes with random back-pressure
        for (int r = 0; r < 6; r++) begin
            do_reset();
            for (int k = 0; k < N; k++) begin
                np = int'($urandom_range(0, 3));
                for (int p = 0; p < np; p++) begin
                    sel = int'($urandom_range(0, 9));
                    if (sel < 6)       len = int'($urandom_range(1, 10));
                    else if (sel == 6) len = MAXP - 1;
                    else if (sel == 7) len = MAXP;
                    else if (sel == 8) len = MAXP + 1;
                    else               len = int'($urandom_range(66, 130));
                    for (int i = 0; i < len; i++)
                        push(k, 8'($urandom_range(0, 255)), i == len - 1);
                end
            end
            full_pct = int'($urandom_range(0, 50));
            drive_lanes();
            build_model();
            drain(20000);
            check_stream("rand");
            chk("rand_ovf", 32'(ovf_cnt), 32'(exp_ovf));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
